// File: rtl/alu_pkg.sv
// Shared types and constants for the pipelined ALU: opcode encoding and flag layout.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_XOR  = 4'd2,
    OP_OR   = 4'd3,
    OP_AND  = 4'd4,
    OP_NOR  = 4'd5,
    OP_NAND = 4'd6,
    OP_XNOR = 4'd7,
    OP_ADC  = 4'd8,
    OP_SBB  = 4'd9,
    OP_SHL  = 4'd10,
    OP_SHR  = 4'd11,
    OP_ASR  = 4'd12,
    OP_ROL  = 4'd13,
    OP_CLC  = 4'd14,
    OP_RSVD = 4'd15
  } alu_op_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

  // Highest opcode of the original 4-bit ALU encoding.
  localparam logic [3:0] OP_LEGACY_MAX = 4'd7;

  // Ops whose carry/borrow is written back into the carry register.
  function automatic logic is_carry_op(alu_op_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADC) || (op == OP_SBB);
  endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Operand-side and result-side valid/ready bus of the pipelined ALU.
interface alu_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [3:0]       out_flags;
  logic             out_illegal;

  // Sequencer/writeback side: drives operands, consumes results.
  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_flags, out_illegal
  );

  // ALU side.
  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_flags, out_illegal
  );
endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU datapath: result, flags and carry-register update.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] result,
  output alu_flags_t       flags,
  output logic             carry_out,
  output logic             carry_we,
  output logic             illegal
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH:0] WIDTH_EXT = (WIDTH+1)'(WIDTH);

  logic [WIDTH:0]     sum_s;
  logic [WIDTH:0]     diff_s;
  logic [WIDTH:0]     cin_ext_s;
  logic [2*WIDTH-1:0] rol_s;
  logic [SHW-1:0]     sh_s;
  logic               sh_big_s;
  logic               c_s;
  logic               v_s;

  // Shared adder/subtractor and shifter terms; ADC/SBB fold in the carry register.
  always_comb begin
    cin_ext_s = '0;
    if ((op == OP_ADC) || (op == OP_SBB)) begin
      cin_ext_s = {{WIDTH{1'b0}}, carry_in};
    end else begin
      cin_ext_s = '0;
    end
    sum_s    = {1'b0, a} + {1'b0, b} + cin_ext_s;
    diff_s   = {1'b0, a} - {1'b0, b} - cin_ext_s;
    sh_s     = b[SHW-1:0];
    sh_big_s = ({1'b0, b} >= WIDTH_EXT);
    rol_s    = {a, a} << sh_s;
  end

  // Opcode decode: select result, carry/overflow and carry-register write.
  always_comb begin
    result    = '0;
    c_s       = 1'b0;
    v_s       = 1'b0;
    carry_out = 1'b0;
    carry_we  = 1'b0;
    illegal   = 1'b0;
    flags     = '0;
    case (op)
      OP_ADD, OP_ADC: begin
        result = sum_s[WIDTH-1:0];
        c_s    = sum_s[WIDTH];
        v_s    = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_SBB: begin
        result = diff_s[WIDTH-1:0];
        c_s    = diff_s[WIDTH];
        v_s    = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_XOR:  result = a ^ b;
      OP_OR:   result = a | b;
      OP_AND:  result = a & b;
      OP_NOR:  result = ~(a | b);
      OP_NAND: result = ~(a & b);
      OP_XNOR: result = ~(a ^ b);
      OP_SHL:  result = sh_big_s ? '0 : (a << sh_s);
      OP_SHR:  result = sh_big_s ? '0 : (a >> sh_s);
      OP_ASR:  result = sh_big_s ? {WIDTH{a[WIDTH-1]}} : $unsigned($signed(a) >>> sh_s);
      OP_ROL:  result = rol_s[2*WIDTH-1:WIDTH];
      OP_CLC: begin
        result   = '0;
        carry_we = 1'b1;
      end
      OP_RSVD: begin
        result  = '0;
        illegal = 1'b1;
      end
      default: begin
        result  = '0;
        illegal = 1'b1;
      end
    endcase

    if (is_carry_op(op)) begin
      carry_we  = 1'b1;
      carry_out = c_s;
    end else begin
      carry_out = 1'b0;
    end

    // A reserved opcode reports no status at all, not even Z.
    if (illegal) begin
      flags = '0;
    end else begin
      flags.n = result[WIDTH-1];
      flags.z = (result == '0);
      flags.c = c_s;
      flags.v = v_s;
    end
  end
endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline: S1 holds operands, S2 holds the result.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic      clock,
  input  logic      reset,
  alu_pipe_if.slave bus
);
  logic             s1_valid_q, s1_valid_d;
  alu_op_e          s1_op_q, s1_op_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_result_q, s2_result_d;
  alu_flags_t       s2_flags_q, s2_flags_d;
  logic             s2_illegal_q, s2_illegal_d;
  logic             carry_q, carry_d;

  logic             s2_adv_s;
  logic             s1_adv_s;
  logic             in_ready_s;
  logic             accept_s;
  logic [WIDTH-1:0] core_result_s;
  alu_flags_t       core_flags_s;
  logic             core_carry_s;
  logic             core_carry_we_s;
  logic             core_illegal_s;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op        (s1_op_q),
    .a         (s1_a_q),
    .b         (s1_b_q),
    .carry_in  (carry_q),
    .result    (core_result_s),
    .flags     (core_flags_s),
    .carry_out (core_carry_s),
    .carry_we  (core_carry_we_s),
    .illegal   (core_illegal_s)
  );

  // Handshake: a stage advances when the stage downstream is empty or draining.
  always_comb begin
    s2_adv_s   = !s2_valid_q || bus.out_ready;
    s1_adv_s   = s1_valid_q && s2_adv_s;
    in_ready_s = !s1_valid_q || s2_adv_s;
    accept_s   = bus.in_valid && in_ready_s;
  end

  // Next-state for both stages and the carry register.
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_op_d      = s1_op_q;
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    s2_valid_d   = s2_valid_q;
    s2_result_d  = s2_result_q;
    s2_flags_d   = s2_flags_q;
    s2_illegal_d = s2_illegal_q;
    carry_d      = carry_q;

    if (accept_s) begin
      s1_valid_d = 1'b1;
      s1_op_d    = alu_op_e'(bus.in_op);
      s1_a_d     = bus.in_a;
      s1_b_d     = bus.in_b;
    end else if (s1_adv_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end

    if (s1_adv_s) begin
      s2_valid_d   = 1'b1;
      s2_result_d  = core_result_s;
      s2_flags_d   = core_flags_s;
      s2_illegal_d = core_illegal_s;
    end else if (bus.out_ready) begin
      s2_valid_d = 1'b0;
    end else begin
      s2_valid_d = s2_valid_q;
    end

    // Carry moves with the op leaving S1 so ADC chains see their predecessor.
    if (s1_adv_s && core_carry_we_s) begin
      carry_d = core_carry_s;
    end else begin
      carry_d = carry_q;
    end
  end

  // Pipeline and carry registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_op_q      <= OP_ADD;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s2_valid_q   <= 1'b0;
      s2_result_q  <= '0;
      s2_flags_q   <= '0;
      s2_illegal_q <= 1'b0;
      carry_q      <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_op_q      <= s1_op_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s2_valid_q   <= s2_valid_d;
      s2_result_q  <= s2_result_d;
      s2_flags_q   <= s2_flags_d;
      s2_illegal_q <= s2_illegal_d;
      carry_q      <= carry_d;
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = s2_valid_q;
  assign bus.out_result  = s2_result_q;
  assign bus.out_flags   = s2_flags_q;
  assign bus.out_illegal = s2_illegal_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed cases plus randomized traffic against a reference model.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W = 8;
  localparam int M = 1 << W;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   flg;
    logic         ill;
  } exp_t;

  logic clock;
  logic reset;
  alu_pipe_if #(.WIDTH(W)) bus ();

  alu_pipe #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int           n_vec = 0;
  int           n_err = 0;
  int           model_cy = 0;
  int           fire_cnt = 0;
  exp_t         exp_q[$];
  logic [W-1:0] log_res [0:1023];
  logic [3:0]   log_flg [0:1023];
  logic         log_ill [0:1023];
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_res;
  logic [3:0]   prev_flg;
  logic         prev_ill;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int to_signed(input int x);
    return (x >= M / 2) ? x - M : x;
  endfunction

  // Reference behaviour computed with plain integer arithmetic.
  function automatic exp_t model(input logic [3:0] op, input int a, input int b);
    exp_t e;
    int r, s, sv, cin, k;
    logic c, v;
    r = 0; c = 1'b0; v = 1'b0;
    e.ill = 1'b0;
    cin = (op == 4'd8 || op == 4'd9) ? model_cy : 0;
    case (op)
      4'd0, 4'd8: begin
        s = a + b + cin; r = s % M; c = (s >= M);
        sv = to_signed(a) + to_signed(b) + cin;
        v = (sv > M / 2 - 1) || (sv < -(M / 2));
      end
      4'd1, 4'd9: begin
        s = a - b - cin; r = (s + M) % M; c = (s < 0);
        sv = to_signed(a) - to_signed(b) - cin;
        v = (sv > M / 2 - 1) || (sv < -(M / 2));
      end
      4'd2:  r = a ^ b;
      4'd3:  r = a | b;
      4'd4:  r = a & b;
      4'd5:  r = (M - 1) & ~(a | b);
      4'd6:  r = (M - 1) & ~(a & b);
      4'd7:  r = (M - 1) & ~(a ^ b);
      4'd10: r = (b >= W) ? 0 : (a << b) % M;
      4'd11: r = (b >= W) ? 0 : (a >> b);
      4'd12: begin k = (b >= W) ? W - 1 : b; r = (to_signed(a) >>> k) & (M - 1); end
      4'd13: begin k = b % W; r = ((a << k) | (a >> (W - k))) % M; end
      4'd14: begin r = 0; model_cy = 0; end
      default: begin r = 0; e.ill = 1'b1; end
    endcase
    if (op == 4'd0 || op == 4'd1 || op == 4'd8 || op == 4'd9) model_cy = c ? 1 : 0;
    e.res = r[W-1:0];
    if (e.ill) e.flg = 4'b0000;
    else e.flg = {(r >= M / 2), (r == 0), c, v};
    return e;
  endfunction

  // One clock: drive, sample at negedge, score, then move past the rising edge.
  task automatic step(input logic v, input logic [3:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic ordy, input logic rst,
                      output logic acc);
    exp_t e;
    bus.in_valid = v; bus.in_op = op; bus.in_a = a; bus.in_b = b;
    bus.out_ready = ordy; reset = rst;
    @(negedge clock);
    acc = v && bus.in_ready && !rst;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("hold_result", {24'd0, bus.out_result}, {24'd0, prev_res});
        chk("hold_flags", {28'd0, bus.out_flags}, {28'd0, prev_flg});
        chk("hold_illegal", {31'd0, bus.out_illegal}, {31'd0, prev_ill});
      end
      if (bus.out_valid && ordy) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("result", {24'd0, bus.out_result}, {24'd0, e.res});
          chk("flags", {28'd0, bus.out_flags}, {28'd0, e.flg});
          chk("illegal", {31'd0, bus.out_illegal}, {31'd0, e.ill});
        end
        log_res[fire_cnt % 1024] = bus.out_result;
        log_flg[fire_cnt % 1024] = bus.out_flags;
        log_ill[fire_cnt % 1024] = bus.out_illegal;
        fire_cnt++;
      end
      if (acc) exp_q.push_back(model(op, int'(a), int'(b)));
      prev_stall = bus.out_valid && !ordy;
      prev_res = bus.out_result; prev_flg = bus.out_flags; prev_ill = bus.out_illegal;
    end
    @(posedge clock);
    #1;
    if (rst) begin
      exp_q.delete();
      model_cy = 0;
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic acc;
    int n;
    acc = 1'b0; n = 0;
    while (!acc && n < 20) begin
      step(1'b1, op, a, b, 1'b1, 1'b0, acc);
      n++;
    end
    if (!acc) chk("issue_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain_to(input int target);
    logic acc;
    int n;
    n = 0;
    while (fire_cnt < target && n < 20) begin
      step(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 1'b0, acc);
      n++;
    end
    chk("drain_count", fire_cnt, target);
  endtask

  task automatic chk_log(input string tag, input int idx, input logic [W-1:0] r, input logic [3:0] f);
    chk({tag, "_res"}, {24'd0, log_res[idx % 1024]}, {24'd0, r});
    chk({tag, "_flags"}, {28'd0, log_flg[idx % 1024]}, {28'd0, f});
  endtask

  initial begin
    logic acc;
    int base;
    logic [3:0] rop;
    logic [W-1:0] ra, rb;

    // Reset state
    step(1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b1, acc);
    step(1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b1, acc);
    reset = 1'b0;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_result", {24'd0, bus.out_result}, 32'd0);
    chk("rst_flags", {28'd0, bus.out_flags}, 32'd0);
    chk("rst_illegal", {31'd0, bus.out_illegal}, 32'd0);

    // 1: ADD 7F+01 and its latency
    base = fire_cnt;
    step(1'b1, OP_ADD, 8'h7F, 8'h01, 1'b1, 1'b0, acc);
    chk("t1_accept", {31'd0, acc}, 32'd1);
    step(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 1'b0, acc);
    chk("t1_lat_early", fire_cnt - base, 32'd0);
    step(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 1'b0, acc);
    chk("t1_lat", fire_cnt - base, 32'd1);
    chk_log("t1", base, 8'h80, 4'b1001);

    // 2: carry chain through ADC and CLC
    base = fire_cnt;
    issue(OP_ADD, 8'hFF, 8'h01);
    issue(OP_ADC, 8'h00, 8'h00);
    issue(OP_CLC, 8'h00, 8'h00);
    issue(OP_ADC, 8'h00, 8'h00);
    drain_to(base + 4);
    chk_log("t2_add", base, 8'h00, 4'b0110);
    chk_log("t2_adc", base + 1, 8'h01, 4'b0000);
    chk_log("t2_clc", base + 2, 8'h00, 4'b0100);
    chk_log("t2_adc2", base + 3, 8'h00, 4'b0100);

    // 3: borrow chain
    base = fire_cnt;
    issue(OP_SUB, 8'h03, 8'h05);
    issue(OP_SBB, 8'h10, 8'h00);
    drain_to(base + 2);
    chk_log("t3_sub", base, 8'hFE, 4'b1010);
    chk_log("t3_sbb", base + 1, 8'h0F, 4'b0000);

    // 4: out-of-range shifts, rotate and reserved opcode
    base = fire_cnt;
    issue(OP_SHR, 8'h80, 8'd9);
    issue(OP_ASR, 8'h80, 8'd9);
    issue(OP_SHL, 8'h01, 8'd9);
    issue(OP_ROL, 8'h81, 8'd9);
    issue(OP_RSVD, 8'h12, 8'h34);
    drain_to(base + 5);
    chk_log("t4_shr", base, 8'h00, 4'b0100);
    chk_log("t4_asr", base + 1, 8'hFF, 4'b1000);
    chk_log("t4_shl", base + 2, 8'h00, 4'b0100);
    chk_log("t4_rol", base + 3, 8'h03, 4'b0000);
    chk_log("t4_rsvd", base + 4, 8'h00, 4'b0000);
    chk("t4_rsvd_ill", {31'd0, log_ill[(base + 4) % 1024]}, 32'd1);

    // 5: backpressure with three transactions
    base = fire_cnt;
    step(1'b1, OP_XOR, 8'h5A, 8'h0F, 1'b0, 1'b0, acc);
    chk("t5_acc0", {31'd0, acc}, 32'd1);
    step(1'b1, OP_ADD, 8'h10, 8'h20, 1'b0, 1'b0, acc);
    chk("t5_acc1", {31'd0, acc}, 32'd1);
    step(1'b1, OP_OR, 8'h30, 8'h03, 1'b0, 1'b0, acc);
    chk("t5_full0", {31'd0, acc}, 32'd0);
    step(1'b1, OP_OR, 8'h30, 8'h03, 1'b0, 1'b0, acc);
    chk("t5_full1", {31'd0, acc}, 32'd0);
    chk("t5_none_out", fire_cnt - base, 32'd0);
    step(1'b1, OP_OR, 8'h30, 8'h03, 1'b1, 1'b0, acc);
    chk("t5_acc2", {31'd0, acc}, 32'd1);
    drain_to(base + 3);
    chk_log("t5_first", base, 8'h55, 4'b0000);
    chk_log("t5_second", base + 1, 8'h30, 4'b0000);
    chk_log("t5_third", base + 2, 8'h33, 4'b0000);

    // 6: reset with both stages full and carry set
    base = fire_cnt;
    issue(OP_ADD, 8'hFF, 8'h01);
    drain_to(base + 1);
    step(1'b1, OP_XOR, 8'h01, 8'h02, 1'b0, 1'b0, acc);
    step(1'b1, OP_OR, 8'h04, 8'h08, 1'b0, 1'b0, acc);
    step(1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b1, acc);
    reset = 1'b0;
    chk("t6_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("t6_in_ready", {31'd0, bus.in_ready}, 32'd1);
    base = fire_cnt;
    issue(OP_ADC, 8'h01, 8'h01);
    drain_to(base + 1);
    chk_log("t6_adc", base, 8'h02, 4'b0000);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra = 8'($urandom);
      rb = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      step(($urandom_range(0, 9) < 7), rop, ra, rb, ($urandom_range(0, 3) != 0), 1'b0, acc);
    end
    drain_to(fire_cnt + exp_q.size());
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, pipelined successor to the team's 4-bit registered ALU. It keeps the same eight-operation encoding in op[2:0] and adds:
- WIDTH-generic operands
- carry-chained arithmetic (ADC/SBB) through an internal carry register
- shifts and rotate
- status flags
- valid/ready handshakes on both sides with full backpressure

It sits between an operand-fetch/sequencer block and a result writeback/accumulator block.

Parameters:
WIDTH, 8, operand/result width; power of two, >= 4.
SHW, $clog2(WIDTH), derived shift-amount width; not overridable.

Ports:
clock  input  1  single clock, rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  operands/op present.
in_ready  output  1  block accepts when in_valid && in_ready.
in_op  input  4  opcode (see Behaviour).
in_a  input  WIDTH  operand A.
in_b  input  WIDTH  operand B / shift amount.
out_valid  output  1  result present.
out_ready  input  1  consumer accepts when out_valid && out_ready.
out_result  output  WIDTH  result.
out_flags  output  4  {N,Z,C,V}.
out_illegal  output  1  reserved opcode was executed.

Behaviour:
Reset:
- Applies only at a clock edge with reset=1.
- Clears s1_valid, s2_valid, carry_q, out_result, out_flags and out_illegal.
- Reset mid-operation discards all in-flight transactions; out_valid=0 from the next cycle. in_ready is combinational and is 1 after reset.

Pipeline:
- Two register stages. S1 captures {op,a,b}. S2 captures {result,flags,illegal}.
- Latency: a transaction accepted at edge k appears on out_* after edge k+1, i.e. out_valid=1 in the cycle after S2 loads.
- Throughput: one transaction per cycle when out_ready=1.

Handshake:
- s2_adv = !s2_valid || out_ready.
- s1_adv = s1_valid && s2_adv.
- in_ready = !s1_valid || s2_adv.
- out_* hold stable while out_valid && !out_ready.
- No transaction is lost or duplicated; order is preserved.
- in_* values are ignored when in_valid=0.

Compute timing:
- Result is computed combinationally from S1 and carry_q, and loaded into S2 on s1_adv.
- carry_q updates on that same edge, so back-to-back ADC chains see the carry of the immediately preceding op.

Opcodes (ops 0-7 are the legacy encoding):
- 0 ADD a+b
- 1 SUB a-b
- 2 XOR
- 3 OR
- 4 AND
- 5 NOR
- 6 NAND
- 7 XNOR
- 8 ADC a+b+carry_q
- 9 SBB a-b-carry_q
- 10 SHL a<<b
- 11 SHR logical a>>b
- 12 ASR arithmetic a>>>b
- 13 ROL a rotated left by b mod WIDTH
- 14 CLC: result 0, clears carry_q
- 15 reserved: result 0, out_illegal=1, flags 0, carry_q unchanged

Shift rules:
- For SHL/SHR/ASR the amount is the full in_b value, unsigned.
- If in_b >= WIDTH: SHL/SHR give 0; ASR gives all copies of a[WIDTH-1].
- ROL uses in_b[SHW-1:0].

Flags:
- Z = (result==0).
- N = result[WIDTH-1].
- C:
  - ADD/ADC: carry-out.
  - SUB/SBB: borrow, 1 when the true difference is < 0.
  - All other ops: 0.
- V: signed overflow for ADD/ADC/SUB/SBB; 0 otherwise.
- carry_q: loaded with C for ops 0,1,8,9; cleared by op 14; unchanged for all others.
- Arithmetic is WIDTH+1 bit internally; result is the low WIDTH bits (wrap-around).

Decomposition:
- Package alu_pkg holds:
  - opcode enum alu_op_e (4 bits, values above)
  - flags struct alu_flags_t {n,z,c,v}
  - OP_LEGACY_MAX=7 constant
- Sub-module alu_core: purely combinational.
  - Inputs: op, a, b, carry_in.
  - Outputs: result, flags, carry_out, carry_we, illegal.
  - Parametrised by WIDTH.
- alu_pipe owns the handshake, both stages and carry_q.

Test Plan:
1. WIDTH=8, ADD 0x7F+0x01, out_ready=1 -> out_result 0x80, flags N=1 Z=0 C=0 V=1; out_valid 2 cycles after acceptance.
2. ADD 0xFF+0x01 then ADC 0x00+0x00 back-to-back, then CLC, then ADC 0x00+0x00 -> results 0x00 {Z=1,C=1}, 0x01 {C=0}, 0x00, 0x00.
3. SUB 0x03-0x05 -> 0xFE, N=1, C=1, V=0; then SBB 0x10-0x00 -> 0x0F.
4. Shifts with b=9: SHR 0x80 -> 0x00 Z=1; ASR 0x80 -> 0xFF; SHL 0x01 -> 0x00; ROL 0x81 -> 0x03. Opcode 15 -> out_illegal=1, result 0.
5. Backpressure: out_ready=0, issue 3 transactions -> in_ready drops after 2 accepted; out_* stable; release -> all 3 emerge in order, no duplicates.
6. Reset asserted for one cycle with both stages full and carry_q=1 -> out_valid=0, in_ready=1 next cycle; subsequent ADC 0x01+0x01 -> 0x02.
